async_fifo_wr_pkt_admit: RTL and testbench

- Write-side packet admission controller, directly upstream of the async FIFO write-port logic, in the wrclk domain.
- Accepts framed packets (sop/eop) over a valid/ready interface and drives the FIFO write side (wrreq, wrdata).
- Starts a packet only when the FIFO-reported fill level guarantees room for a maximum-length packet, so packets are never split by FIFO full.
- Truncates oversize packets and discards orphan words.

---
 rtl/async_fifo_wr_pkt_admit_pkg.sv | 27 ++
 rtl/async_fifo_wr_out_stage.sv | 39 +++
 rtl/async_fifo_wr_pkt_admit.sv | 162 ++++++++++++++++
 tb/tb_async_fifo_wr_pkt_admit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_wr_pkt_admit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_wr_pkt_admit_pkg
// Brief    : Shared state encoding and helpers for the write-side packet admitter
// Revision : 1.0 - initial release
// ============================================================================
package async_fifo_wr_pkt_admit_pkg;

  localparam int         c_STATE_W  = 3;
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_ADMIT = 3'd1;
  localparam logic [2:0] c_ST_XFER  = 3'd2;
  localparam logic [2:0] c_ST_DRAIN = 3'd3;
  localparam logic [2:0] c_ST_GAP   = 3'd4;

  // Free words in a 2^aw deep FIFO given its fill level.
  function automatic logic [31:0] free_space(input logic [31:0] used, input int unsigned aw);
    free_space = ((32'd1 << aw) - 32'd1) - used;
  endfunction

  // The eop flag sits just above the payload in the FIFO word.
  function automatic int unsigned eop_bit(input int unsigned dw);
    eop_bit = dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/async_fifo_wr_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_wr_out_stage
// Brief    : One-entry output register feeding the FIFO write port, stalls on full
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_wr_out_stage #(
  parameter int WIDTH = 33
) (
  input  logic             wrclk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_wrfull,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Caller only loads when the entry is empty or being written this cycle.
  always_ff @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && !i_wrfull) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/async_fifo_wr_pkt_admit.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_wr_pkt_admit
// Brief    : Admits whole packets into an async FIFO only when a max-size packet fits
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_wr_pkt_admit
  import async_fifo_wr_pkt_admit_pkg::*;
#(
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_PKT_LEN     = 16,
  parameter int SPACE_MARGIN    = 4,
  parameter int GAP_CYCLES      = 3
) (
  input  logic                       wrclk,
  input  logic                       reset_n,
  input  logic                       i_src_valid,
  output logic                       o_src_ready,
  input  logic [DATA_WIDTH-1:0]      i_src_data,
  input  logic                       i_src_sop,
  input  logic                       i_src_eop,
  output logic                       o_wrreq,
  output logic [DATA_WIDTH:0]        o_wrdata,
  input  logic [FIFO_ADDR_WIDTH-1:0] i_wrusedw,
  input  logic                       i_wrfull,
  output logic [15:0]                o_pkt_cnt,
  output logic [15:0]                o_drop_cnt,
  output logic                       o_trunc_err,
  output logic                       o_orphan_err
);

  localparam int                 c_CNT_W     = $clog2(MAX_PKT_LEN + 1);
  localparam int                 c_GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam int                 c_EOP_BIT   = eop_bit(DATA_WIDTH);
  localparam logic [31:0]        c_ADMIT_MIN = 32'(MAX_PKT_LEN + SPACE_MARGIN);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(MAX_PKT_LEN);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(GAP_CYCLES - 1);

  logic [c_STATE_W-1:0] r_state, w_state_nxt;
  logic                 r_run;
  logic [c_CNT_W-1:0]   r_word_cnt;
  logic [c_GAP_W-1:0]   r_gap_cnt;
  logic [15:0]          r_pkt_cnt, r_drop_cnt;
  logic                 r_trunc_err, r_orphan_err;

  logic                 w_out_valid, w_admit, w_gap_done, w_accept;
  logic                 w_ready, w_load, w_eop_out, w_trunc, w_orphan, w_drop, w_pkt_done;
  logic [31:0]          w_free;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [DATA_WIDTH:0]  w_load_data;

  // wrusedw wraps to 0 when full, so wrfull must veto admission as well.
  assign w_free     = free_space(32'(i_wrusedw), FIFO_ADDR_WIDTH);
  assign w_admit    = !i_wrfull && (w_free >= c_ADMIT_MIN);
  assign w_cnt_nxt  = r_word_cnt + c_CNT_W'(1);
  assign w_gap_done = !w_out_valid && (r_gap_cnt == c_GAP_LAST);
  assign w_accept   = i_src_valid && o_src_ready;

  always_ff @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (i_src_valid && i_src_sop) w_state_nxt = c_ST_ADMIT;
      c_ST_ADMIT: if (w_admit) w_state_nxt = c_ST_XFER;
      c_ST_XFER: begin
        if (w_accept && i_src_eop)                     w_state_nxt = c_ST_GAP;
        else if (w_accept && (w_cnt_nxt == c_CNT_MAX)) w_state_nxt = c_ST_DRAIN;
      end
      c_ST_DRAIN: if (w_accept && i_src_eop) w_state_nxt = c_ST_GAP;
      c_ST_GAP:   if (w_gap_done) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready    = 1'b0;
    w_load     = 1'b0;
    w_trunc    = 1'b0;
    w_orphan   = 1'b0;
    w_drop     = 1'b0;
    w_pkt_done = 1'b0;
    w_eop_out  = i_src_eop || (w_cnt_nxt == c_CNT_MAX);
    case (r_state)
      c_ST_IDLE: begin
        w_ready  = !(i_src_valid && i_src_sop);
        w_orphan = r_run && i_src_valid && !i_src_sop;
        w_drop   = w_orphan;
      end
      c_ST_XFER: begin
        w_ready    = !w_out_valid || !i_wrfull;
        w_load     = i_src_valid && w_ready;
        w_pkt_done = w_load && w_eop_out;
        w_trunc    = w_load && !i_src_eop && (w_cnt_nxt == c_CNT_MAX);
      end
      c_ST_DRAIN: begin
        w_ready = 1'b1;
        w_drop  = i_src_valid;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_load_data            = {1'b0, i_src_data};
    w_load_data[c_EOP_BIT] = w_eop_out;
  end

  // Holds ready low for the first cycle out of reset.
  always_ff @(posedge wrclk or negedge reset_n) begin
    if (!reset_n) begin
      r_run        <= 1'b0;
      r_word_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_pkt_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_trunc_err  <= 1'b0;
      r_orphan_err <= 1'b0;
    end else begin
      r_run        <= 1'b1;
      r_trunc_err  <= w_trunc;
      r_orphan_err <= w_orphan;
      if (w_pkt_done) r_pkt_cnt  <= r_pkt_cnt + 16'd1;
      if (w_drop)     r_drop_cnt <= r_drop_cnt + 16'd1;
      if (r_state != c_ST_XFER) r_word_cnt <= '0;
      else if (w_load)          r_word_cnt <= w_cnt_nxt;
      // GAP counts only cycles after the final word has left the out-stage.
      if (r_state == c_ST_GAP && !w_out_valid && !w_gap_done) r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
      else                                                     r_gap_cnt <= '0;
    end
  end

  async_fifo_wr_out_stage #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_out_stage (
    .wrclk    (wrclk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_data   (w_load_data),
    .i_wrfull (i_wrfull),
    .o_valid  (w_out_valid),
    .o_data   (o_wrdata)
  );

  assign o_src_ready  = w_ready && r_run;
  assign o_wrreq      = w_out_valid;
  assign o_pkt_cnt    = r_pkt_cnt;
  assign o_drop_cnt   = r_drop_cnt;
  assign o_trunc_err  = r_trunc_err;
  assign o_orphan_err = r_orphan_err;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_pkt_admit.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo_wr_pkt_admit
// Brief    : Scoreboard bench for the write-side packet admitter
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_pkt_admit;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int MAXL = 16;

  logic          wrclk = 1'b0;
  logic          reset_n = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [DW-1:0] src_data = '0;
  logic          src_sop = 1'b0;
  logic          src_eop = 1'b0;
  logic          wrreq;
  logic [DW:0]   wrdata;
  logic [AW-1:0] wrusedw = '0;
  logic          wrfull = 1'b0;
  logic [15:0]   pkt_cnt, drop_cnt;
  logic          trunc_err, orphan_err;

  async_fifo_wr_pkt_admit #(
    .FIFO_ADDR_WIDTH (AW),
    .DATA_WIDTH      (DW),
    .MAX_PKT_LEN     (MAXL),
    .SPACE_MARGIN    (4),
    .GAP_CYCLES      (3)
  ) dut (
    .wrclk        (wrclk),
    .reset_n      (reset_n),
    .i_src_valid  (src_valid),
    .o_src_ready  (src_ready),
    .i_src_data   (src_data),
    .i_src_sop    (src_sop),
    .i_src_eop    (src_eop),
    .o_wrreq      (wrreq),
    .o_wrdata     (wrdata),
    .i_wrusedw    (wrusedw),
    .i_wrfull     (wrfull),
    .o_pkt_cnt    (pkt_cnt),
    .o_drop_cnt   (drop_cnt),
    .o_trunc_err  (trunc_err),
    .o_orphan_err (orphan_err)
  );

  always #5 wrclk = ~wrclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [DW:0] exp_q[$];
  int          exp_pkt = 0, exp_drop = 0, exp_trunc = 0, exp_orph = 0;
  int          obs_trunc = 0, obs_orph = 0, n_wr = 0;
  int          cyc = 0, first_wr = -1, last_wr = -1;
  logic        p_wrreq = 1'b0, p_wrfull = 1'b0;
  logic [DW:0] p_wrdata = '0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge wrclk) begin
    cyc++;
    if (reset_n) begin
      if (trunc_err)  obs_trunc++;
      if (orphan_err) obs_orph++;
      if (p_wrreq && p_wrfull) begin
        chk_eq("hold_wrreq", 64'(wrreq), 64'd1);
        chk_eq("hold_wrdata", 64'(wrdata), 64'(p_wrdata));
      end
      if (wrreq && wrfull) chk_eq("stall_ready", 64'(src_ready), 64'd0);
      if (wrreq && !wrfull) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (exp_q.size() == 0) chk_eq("unexpected_write", 64'(exp_q.size()), 64'd1);
        else                   chk_eq("wrdata", 64'(wrdata), 64'(exp_q.pop_front()));
      end
    end
    p_wrreq  = wrreq;
    p_wrfull = wrfull;
    p_wrdata = wrdata;
  end

  task automatic send_word(input logic [DW-1:0] d, input logic sop, input logic eop,
                           input logic [DW:0] exp, input bit push);
    int t = 0;
    src_valid = 1'b1;
    src_data  = d;
    src_sop   = sop;
    src_eop   = eop;
    @(negedge wrclk);
    while (!src_ready && t < 300) begin
      t++;
      @(negedge wrclk);
    end
    if (!src_ready) chk_eq("ready_timeout", 64'(t), 64'd0);
    else if (push)  exp_q.push_back(exp);
    @(posedge wrclk);
    #1;
    src_valid = 1'b0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int nsend);
    logic [DW-1:0] base;
    logic [DW-1:0] d;
    logic          eop_w;
    base = DW'($urandom);
    for (int k = 1; k <= nsend; k++) begin
      d     = base + DW'(k);
      eop_w = (k == len) || (k == MAXL);
      if (k <= MAXL) begin
        if (eop_w) exp_pkt++;
        if (k == MAXL && len > MAXL) exp_trunc++;
      end else begin
        exp_drop++;
      end
      send_word(d, k == 1, k == len, {eop_w, d}, k <= MAXL);
    end
  endtask

  task automatic wait_idle();
    repeat (12) @(posedge wrclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_wrreq"},  64'(wrreq),      64'd0);
    chk_eq({tag, "_wrdata"}, 64'(wrdata),     64'd0);
    chk_eq({tag, "_ready"},  64'(src_ready),  64'd0);
    chk_eq({tag, "_pkt"},    64'(pkt_cnt),    64'd0);
    chk_eq({tag, "_drop"},   64'(drop_cnt),   64'd0);
    chk_eq({tag, "_trunc"},  64'(trunc_err),  64'd0);
    chk_eq({tag, "_orphan"}, 64'(orphan_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int wr0;
    repeat (3) @(posedge wrclk);
    #1;
    chk_all_zero("reset");
    @(negedge wrclk);
    reset_n = 1'b1;
    @(posedge wrclk);
    #1;

    // 4-word packet into an empty FIFO, no backpressure
    wr0      = n_wr;
    first_wr = -1;
    send_pkt(4, 4);
    wait_idle();
    chk_eq("p4_writes", 64'(n_wr - wr0), 64'd4);
    chk_eq("p4_consecutive", 64'(last_wr - first_wr + 1), 64'd4);
    chk_eq("p4_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    chk_eq("p4_queue", 64'(exp_q.size()), 64'd0);

    // admission blocked at free=15, opens at free=20
    wrusedw = 8'd240;
    fork
      send_pkt(4, 4);
      begin
        repeat (10) begin
          @(negedge wrclk);
          chk_eq("admit_hold_ready", 64'(src_ready), 64'd0);
          chk_eq("admit_hold_wrreq", 64'(wrreq), 64'd0);
        end
        @(posedge wrclk);
        #1;
        wrusedw = 8'd235;
        @(posedge wrclk);
        @(negedge wrclk);
        chk_eq("admit_go_ready", 64'(src_ready), 64'd1);
      end
    join
    wrusedw = '0;
    wait_idle();
    chk_eq("admit_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    chk_eq("admit_queue", 64'(exp_q.size()), 64'd0);

    // wrfull stall mid-packet
    fork
      send_pkt(8, 8);
      begin
        repeat (6) @(posedge wrclk);
        #1;
        wrfull = 1'b1;
        repeat (5) @(posedge wrclk);
        #1;
        wrfull = 1'b0;
      end
    join
    wait_idle();
    chk_eq("stall_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    chk_eq("stall_queue", 64'(exp_q.size()), 64'd0);

    // oversize packet truncated at MAXL
    send_pkt(20, 20);
    wait_idle();
    chk_eq("trunc_pulses", 64'(obs_trunc), 64'(exp_trunc));
    chk_eq("trunc_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk_eq("trunc_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    chk_eq("trunc_queue", 64'(exp_q.size()), 64'd0);

    // orphan words in IDLE
    wr0 = n_wr;
    for (int i = 0; i < 3; i++) begin
      exp_drop++;
      exp_orph++;
      send_word(DW'($urandom), 1'b0, 1'b0, '0, 1'b0);
    end
    wait_idle();
    chk_eq("orphan_pulses", 64'(obs_orph), 64'(exp_orph));
    chk_eq("orphan_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    chk_eq("orphan_no_write", 64'(n_wr - wr0), 64'd0);

    // reset during word 3 of an 8-word packet
    send_pkt(8, 2);
    src_valid = 1'b1;
    src_data  = DW'($urandom);
    @(negedge wrclk);
    #1;
    chk_eq("midrst_queue", 64'(exp_q.size()), 64'd0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    exp_pkt   = 0;
    exp_drop  = 0;
    exp_trunc = 0;
    exp_orph  = 0;
    obs_trunc = 0;
    obs_orph  = 0;
    src_valid = 1'b0;
    @(negedge wrclk);
    reset_n = 1'b1;
    @(posedge wrclk);
    #1;
    wr0 = n_wr;
    send_pkt(5, 5);
    wait_idle();
    chk_eq("postrst_writes", 64'(n_wr - wr0), 64'd5);
    chk_eq("postrst_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    chk_eq("postrst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk_eq("postrst_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
